// File: rtl/taylor_pkg.sv
// Shared fixed-point definitions for the cosine pipeline (angle reducer and Taylor series).
// Contents:
//   FXP_W / FXP_FRAC / RED_STEPS  angle format and reduction step count
//   fxp_t / ufxp_t                 signed and unsigned angle types
//   TWO_PI / PI / HALF_PI          angle constants scaled by 2^FXP_FRAC
//   state_t                        reducer FSM states
package taylor_pkg;

  localparam int unsigned FXP_W     = 24;
  localparam int unsigned FXP_FRAC  = 10;
  localparam int unsigned RED_STEPS = 11;

  typedef logic signed [FXP_W-1:0] fxp_t;
  typedef logic        [FXP_W-1:0] ufxp_t;

  // round(x * 1024), except HALF_PI which is floored so the fold never exceeds pi/2.
  localparam int unsigned TWO_PI  = 6434;
  localparam int unsigned PI      = 3217;
  localparam int unsigned HALF_PI = 1608;

  typedef enum logic [2:0] {
    StIdle,
    StAbs,
    StReduce,
    StFold2Pi,
    StFoldPi,
    StDone
  } state_t;

endpackage

// File: rtl/angle_range_reducer.sv
// Folds a signed fixed-point angle into [0, HALF_PI] plus a flag telling the downstream stage
// to negate the cosine. Multi-cycle: abs, RED_STEPS shift-subtract steps, two folds, done.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   start       accept angle_in (sampled only when idle)
//   angle_in    signed angle, FXP_FRAC fractional bits
//   ready_out   one-cycle pulse, angle_out/negate_out valid
//   busy_out    high from accept through the ready_out cycle
//   angle_out   reduced angle, unsigned
//   negate_out  1 = cosine must be negated downstream
module angle_range_reducer
  import taylor_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [FXP_W-1:0] angle_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic [FXP_W-1:0] angle_out,
  output logic             negate_out
);

  localparam int unsigned WorkW = FXP_W + 1;
  localparam int unsigned StepW = $clog2(RED_STEPS);

  typedef logic [WorkW-1:0] work_t;

  // Most negative input, sign-extended into the working width; its magnitude does not fit.
  localparam work_t MinNeg = {2'b11, {(FXP_W-1){1'b0}}};
  localparam work_t SatMax = {2'b00, {(FXP_W-1){1'b1}}};

  state_t           state_q, state_d;
  work_t            r_q, r_d;
  logic [StepW-1:0] step_q, step_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [FXP_W-1:0] angle_q, angle_d;
  logic             neg_q, neg_d;

  work_t step_val;
  work_t op_a, op_b, diff, thresh;
  logic  hit;

  assign step_val = work_t'(TWO_PI) << step_q;

  // One subtractor and one comparator shared across every phase via operand muxing.
  always_comb begin
    op_a   = r_q;
    op_b   = step_val;
    thresh = work_t'(PI);
    unique case (state_q)
      StAbs: begin
        op_a = '0;
        op_b = r_q;
      end
      StFold2Pi: begin
        op_a   = work_t'(TWO_PI);
        op_b   = r_q;
        thresh = work_t'(PI);
      end
      StFoldPi: begin
        op_a   = work_t'(PI);
        op_b   = r_q;
        thresh = work_t'(HALF_PI);
      end
      default: ;
    endcase
  end

  assign diff = op_a - op_b;
  assign hit  = (state_q == StReduce) ? (r_q >= step_val) : (r_q > thresh);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    step_d  = step_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    angle_d = angle_q;
    neg_d   = neg_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          r_d     = {angle_in[FXP_W-1], angle_in};
          busy_d  = 1'b1;
          state_d = StAbs;
        end
      end
      StAbs: begin
        if (r_q == MinNeg) begin
          r_d = SatMax;
        end else if (r_q[WorkW-1]) begin
          r_d = diff;
        end
        step_d  = StepW'(RED_STEPS - 1);
        state_d = StReduce;
      end
      StReduce: begin
        if (hit) r_d = diff;
        if (step_q == '0) begin
          state_d = StFold2Pi;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      StFold2Pi: begin
        if (hit) r_d = diff;
        state_d = StFoldPi;
      end
      StFoldPi: begin
        // Result goes straight to the output registers so it is valid on entering DONE.
        angle_d = hit ? diff[FXP_W-1:0] : r_q[FXP_W-1:0];
        neg_d   = hit;
        ready_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      r_q     <= '0;
      step_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      angle_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      step_q  <= step_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      angle_q <= angle_d;
      neg_q   <= neg_d;
    end
  end

  assign ready_out  = ready_q;
  assign busy_out   = busy_q;
  assign angle_out  = angle_q;
  assign negate_out = neg_q;

endmodule

// File: tb/tb_angle_range_reducer.sv
// Scoreboard bench for angle_range_reducer: the driver pushes model results at accept time,
// an independent monitor pops and compares whenever ready_out is seen.
module tb_angle_range_reducer;

  localparam longint TwoPi  = 6434;
  localparam longint Pi     = 3217;
  localparam longint HalfPi = 1608;
  localparam longint Lat    = 15;  // edges from the sample before accept to ready visible

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] angle_in;
  logic        ready_out;
  logic        busy_out;
  logic [23:0] angle_out;
  logic        negate_out;

  angle_range_reducer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .angle_in   (angle_in),
    .ready_out  (ready_out),
    .busy_out   (busy_out),
    .angle_out  (angle_out),
    .negate_out (negate_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint ang;
    bit     neg;
    longint acc;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void ref_reduce(input logic [23:0] a, output longint ang, output bit neg);
    longint v;
    v = longint'($signed(a));
    if (v < 0) v = -v;
    if (v > 8388607) v = 8388607;
    v = v % TwoPi;
    if (v > Pi) v = TwoPi - v;
    if (v > HalfPi) begin
      v   = Pi - v;
      neg = 1'b1;
    end else begin
      neg = 1'b0;
    end
    ang = v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready_out pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && ready_out) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: got ready_out=1 expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("angle_out", longint'(angle_out), e.ang);
        check("negate_out", longint'(negate_out), longint'(e.neg));
        check("latency", cyc - e.acc, Lat);
        check("busy_in_ready_cycle", longint'(busy_out), 1);
      end
    end
  end

  task automatic issue(input logic [23:0] a);
    exp_t e;
    longint ang;
    bit neg;
    ref_reduce(a, ang, neg);
    @(negedge clock);
    start    = 1'b1;
    angle_in = a;
    e.ang = ang;
    e.neg = neg;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clock);
    start    = 1'b0;
    angle_in = 24'($urandom);
    check("busy_after_accept", longint'(busy_out), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_out && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (busy_out) check("idle_timeout", 1, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, longint'(ready_out), 0);
    check({tag, "_busy"}, longint'(busy_out), 0);
    check({tag, "_angle"}, longint'(angle_out), 0);
    check({tag, "_negate"}, longint'(negate_out), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] dir[$];
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b0;

    dir = '{24'd0, 24'd1024, 24'd2048, 24'd4000, -24'sd7000, 24'h800000, 24'd3217,
            24'd1608, 24'd6434, 24'd3218, 24'd1609, 24'h7fffff};
    foreach (dir[i]) begin
      issue(dir[i]);
      wait_idle();
    end

    for (int i = 0; i < 20; i++) begin
      issue(24'($urandom));
      wait_idle();
    end
    for (int i = 0; i < 10; i++) begin
      issue(24'($signed($urandom_range(40000)) - 20000));
      wait_idle();
    end

    // Second start while busy must be ignored.
    issue(24'd2048);
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clock);

    // Reset mid-operation aborts silently.
    issue(24'd4000);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    void'(sb.pop_back());
    check_cleared("mid_reset");
    repeat (25) @(negedge clock);
    issue(-24'sd7000);
    wait_idle();

    // Reset wins over a simultaneous start.
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check("reset_over_start_busy", longint'(busy_out), 0);
    repeat (20) @(negedge clock);

    // start held high: one accept every 16 edges, input churn between accepts is ignored.
    begin
      exp_t e;
      longint ang;
      bit neg;
      logic [23:0] a;
      a = 24'($urandom);
      ref_reduce(a, ang, neg);
      @(negedge clock);
      start    = 1'b1;
      angle_in = a;
      e.ang = ang; e.neg = neg; e.acc = cyc;
      sb.push_back(e);
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 16; j++) begin
          @(negedge clock);
          if (j == 15) begin
            a = 24'($urandom);
            ref_reduce(a, ang, neg);
            angle_in = a;
            e.ang = ang; e.neg = neg; e.acc = cyc;
            sb.push_back(e);
          end else begin
            angle_in = 24'($urandom);
          end
        end
      end
      @(negedge clock);
      start = 1'b0;
    end

    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("pending_results", longint'(sb.size()), 0);
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
